audio_pwm_tx: RTL and testbench
===============================

# audio_pwm_tx

Sample-driven PWM transmitter for the board's mono audio output (`aud_pwm`); it is the output-direction counterpart to the input conditioning on the buttons. The CPU's memory-mapped IO pushes unsigned PCM samples through a valid/ready handshake into a small FIFO. The block pops one sample per PWM period and drives a registered, duty-modulated pulse train. It sits in the top level between `Riscv151`'s audio IO port and the `aud_pwm` pin, and `aud_sd` stays tied high.

## Interface
- `CPU_CLOCK_FREQ`, 100_000_000: clock frequency in Hz; informational only, no internal division.
- `SAMPLE_WIDTH`, 10: sample and duty width W; PWM period is 2^W cycles (1024 cycles, 97.66 kHz at 100 MHz).
- `FIFO_DEPTH`, 4: sample FIFO entries; power of two, 2 or more.
- `clk`  in  1  CPU clock (`cpu_clk_g`).
- `rst`  in  1  asynchronous, active-high reset.
- `sample_in`  in  W  unsigned sample; duty = sample / 2^W.
- `sample_in_valid`  in  1  producer has a sample.
- `sample_in_ready`  out  1  FIFO can accept a sample.
- `enable`  in  1  run the PWM; low means idle and silent.
- `aud_pwm`  out  1  PWM output, registered.
- `underflow`  out  1  one-cycle pulse when a sample was needed and the FIFO was empty.
- `fifo_count`  out  clog2(FIFO_DEPTH+1)  current occupancy.

## Operation
- **Reset values (async):** period counter 0, duty register 0, FIFO empty, `fifo_count` 0, `aud_pwm` 0, `underflow` 0. `sample_in_ready` reads 1 after reset, because it is derived from the count.
- **Push:** a push happens when `sample_in_valid && sample_in_ready`.
  - `sample_in_ready = (fifo_count != FIFO_DEPTH)`, combinational from the count only.
  - There is no dependence on `valid` and no bypass path into the duty register.
- **Period counter:** a W-bit counter.
  - When `enable` is high it increments every cycle and wraps from 2^W−1 to 0.
  - When `enable` is low it is forced to 0.
- **Load event:** `enable && counter == 2^W−1`.
  - If the FIFO is non-empty, pop its head into the duty register.
  - If the FIFO is empty, hold the duty register and pulse `underflow` for that cycle.
- **Output:** `aud_pwm <= enable && (counter < duty)`.
  - Duty 0 gives a constant low output.
  - Duty 2^W−1 gives 2^W−1 high cycles per period; 100% duty is not representable.
- **Enable low:** no pops and no underflow. Pushes are still accepted, so the FIFO can be pre-filled before enabling.
- **Enable rising:** the counter starts at 0 and the first period uses the current duty register. The first pop occurs at the end of that first period.
- **Simultaneous push and pop:** with 0 < count < DEPTH the count is unchanged and FIFO order is preserved. When full, `ready` is 0, so only the pop occurs. When empty, no pop can occur; underflow follows the rule above even if a push lands in the same cycle.
- **Wrap-around:** FIFO read and write pointers are log2(DEPTH) bits and wrap naturally. Count is tracked separately to distinguish full from empty.

## Timing
- **Push to count:** `fifo_count` updates on the edge following a handshake cycle.
- **Pop to output:** a sample popped at the load event at cycle t drives `aud_pwm` from cycle t+2. That is the counter-0 compare at t+1, registered at t+2.
- **Output latency:** `aud_pwm` lags the counter compare by exactly 1 cycle.
- **Underflow pulse:** `underflow` is asserted in the same cycle as the load event (combinational from state), one cycle wide.
- **Reset mid-period:** output goes low asynchronously, queued samples are discarded, and counting resumes from 0 on the first `enable` cycle after release.
- **Throughput:** at most one sample per 2^W cycles is consumed; the producer may push one sample per cycle until full.

## Structure
- Shared constants go in the project audio header/package: default `SAMPLE_WIDTH`, `FIFO_DEPTH`, and the MMIO offset of the sample register.
- Sub-module `sync_fifo` (parameters: width, depth) holds the storage, pointers, count and full/empty flags. It is reused later by other IO blocks.
- The top of the block holds the period counter, duty register, compare/output flop and underflow logic.

## Test plan
- **Fill to full:** reset, `enable`=0, push 5 samples back-to-back. Expect `ready` to fall after the 4th push, `fifo_count`=4, the 5th sample not accepted, and `aud_pwm` to stay 0.
- **Duty check:** preload 256, enable, observe two periods. First period is all low (duty 0). Second period has exactly 256 high cycles starting 2 cycles after the load event, then 768 low cycles.
- **Extreme duties:** samples 0 and 1023 produce 0 and 1023 high cycles per 1024-cycle period respectively.
- **Underflow hold:** push one sample of 512 and enable. Expect `underflow` high for one cycle at the second load event, and duty 512 repeated in the following period.
- **Push on the load cycle:** push a sample on the same cycle as the load event with count=2. Expect the count to stay 2, the popped value to be the older head, and FIFO order preserved over 3 more periods.
- **Async reset mid-period:** assert `rst` at counter=300 with 3 samples queued. Expect `aud_pwm`=0 immediately, `fifo_count`=0, `ready`=1, and the counter restarting at 0 after release.

Source files
------------

// File: rtl/audio_pwm_tx_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : audio_pwm_tx_pkg
//  Description : Shared constants for the audio PWM output path: default
//                sample width, default sample FIFO depth and the MMIO offset
//                of the sample register.
//  Revision    : 1.0 - initial release
// ============================================================================
package audio_pwm_tx_pkg;

    localparam int          AUDIO_SAMPLE_WIDTH       = 10;
    localparam int          AUDIO_FIFO_DEPTH         = 4;
    localparam logic [31:0] AUDIO_SAMPLE_MMIO_OFFSET = 32'h0000_0050;

endpackage : audio_pwm_tx_pkg
`default_nettype wire

// File: rtl/audio_pwm_tx_sync_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : sync_fifo
//  Description : Single-clock FIFO with valid/ready write side, pop-enable
//                read side and a show-ahead head word. Occupancy is counted
//                separately so full and empty are unambiguous while the
//                pointers wrap naturally.
//  Revision    : 1.0 - initial release
// ============================================================================
module sync_fifo #(
    parameter  int WIDTH       = 10,
    parameter  int DEPTH       = 4,
    localparam int PTR_WIDTH   = $clog2(DEPTH),
    localparam int COUNT_WIDTH = $clog2(DEPTH + 1)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   wr_valid,
    input  logic [WIDTH-1:0]       wr_data,
    output logic                   wr_ready,
    input  logic                   rd_en,
    output logic [WIDTH-1:0]       rd_data,
    output logic                   empty,
    output logic                   full,
    output logic [COUNT_WIDTH-1:0] count
);

    localparam logic [COUNT_WIDTH-1:0] c_depth   = COUNT_WIDTH'(DEPTH);
    localparam logic [COUNT_WIDTH-1:0] c_cnt_one = COUNT_WIDTH'(1);
    localparam logic [PTR_WIDTH-1:0]   c_ptr_one = PTR_WIDTH'(1);

    logic [WIDTH-1:0]       mem_q [DEPTH];
    logic [PTR_WIDTH-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_WIDTH-1:0]   rd_ptr_q, rd_ptr_d;
    logic [COUNT_WIDTH-1:0] count_q, count_d;
    logic                   do_wr;
    logic                   do_rd;

    assign full     = (count_q == c_depth);
    assign empty    = (count_q == '0);
    assign wr_ready = !full;
    assign count    = count_q;
    assign rd_data  = mem_q[rd_ptr_q];

    // Next-state for pointers and occupancy; guarded so over/underrun is impossible.
    always_comb begin
        do_wr    = wr_valid && !full;
        do_rd    = rd_en && !empty;
        wr_ptr_d = do_wr ? wr_ptr_q + c_ptr_one : wr_ptr_q;
        rd_ptr_d = do_rd ? rd_ptr_q + c_ptr_one : rd_ptr_q;
        count_d  = count_q;
        if (do_wr && !do_rd) begin
            count_d = count_q + c_cnt_one;
        end else if (do_rd && !do_wr) begin
            count_d = count_q - c_cnt_one;
        end
    end

    // Storage array; contents need no reset because count gates visibility.
    always_ff @(posedge clk) begin
        if (do_wr) begin
            mem_q[wr_ptr_q] <= wr_data;
        end
    end

    // Pointer and occupancy registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule : sync_fifo
`default_nettype wire

// File: rtl/audio_pwm_tx.sv
`default_nettype none
// ============================================================================
//  Module      : audio_pwm_tx
//  Description : Sample-driven PWM transmitter. PCM samples are queued in a
//                small FIFO; one sample is loaded into the duty register at
//                the end of every 2^W-cycle period and compared against the
//                period counter to produce a registered pulse train.
//  Revision    : 1.0 - initial release
// ============================================================================
module audio_pwm_tx
    import audio_pwm_tx_pkg::*;
#(
    parameter int CPU_CLOCK_FREQ = 100_000_000,
    parameter int SAMPLE_WIDTH   = AUDIO_SAMPLE_WIDTH,
    parameter int FIFO_DEPTH     = AUDIO_FIFO_DEPTH
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic [SAMPLE_WIDTH-1:0]          sample_in,
    input  logic                             sample_in_valid,
    output logic                             sample_in_ready,
    input  logic                             enable,
    output logic                             aud_pwm,
    output logic                             underflow,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]  fifo_count
);

    localparam logic [SAMPLE_WIDTH-1:0] c_period_last = '1;
    localparam logic [SAMPLE_WIDTH-1:0] c_cnt_one     = SAMPLE_WIDTH'(1);

    // Reject parameter sets the pointer arithmetic cannot support.
    if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0 || CPU_CLOCK_FREQ <= 0) begin : g_bad_params
        $error("audio_pwm_tx: FIFO_DEPTH must be a power of two >= 2 and CPU_CLOCK_FREQ positive");
    end

    logic [SAMPLE_WIDTH-1:0] counter_q, counter_d;
    logic [SAMPLE_WIDTH-1:0] duty_q, duty_d;
    logic                    aud_pwm_q, aud_pwm_d;
    logic [SAMPLE_WIDTH-1:0] fifo_head;
    logic                    fifo_empty;
    logic                    fifo_full;
    logic                    load_event;
    logic                    pop;

    sync_fifo #(
        .WIDTH (SAMPLE_WIDTH),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .wr_valid (sample_in_valid),
        .wr_data  (sample_in),
        .wr_ready (sample_in_ready),
        .rd_en    (pop),
        .rd_data  (fifo_head),
        .empty    (fifo_empty),
        .full     (fifo_full),
        .count    (fifo_count)
    );

    // Last cycle of a running period: time to fetch the next duty value.
    always_comb begin
        load_event = enable && (counter_q == c_period_last);
        pop        = load_event && !fifo_empty;
        underflow  = load_event && fifo_empty;
    end

    // Counter runs only while enabled; duty is replaced on pop and held on underflow.
    always_comb begin
        counter_d = enable ? counter_q + c_cnt_one : '0;
        duty_d    = pop ? fifo_head : duty_q;
        aud_pwm_d = enable && (counter_q < duty_q);
    end

    // Period counter, duty register and output flop.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            counter_q <= '0;
            duty_q    <= '0;
            aud_pwm_q <= 1'b0;
        end else begin
            counter_q <= counter_d;
            duty_q    <= duty_d;
            aud_pwm_q <= aud_pwm_d;
        end
    end

    assign aud_pwm = aud_pwm_q;

endmodule : audio_pwm_tx
`default_nettype wire

// File: tb/tb_audio_pwm_tx.sv
`default_nettype none
// ============================================================================
//  Module      : tb_audio_pwm_tx
//  Description : Directed bench for audio_pwm_tx: reset state, FIFO fill,
//                duty accuracy, extreme duties, underflow hold, push on the
//                load cycle and asynchronous reset mid-period.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_audio_pwm_tx;

    localparam int W      = 10;
    localparam int DEPTH  = 4;
    localparam int PERIOD = 1 << W;
    localparam int CW     = $clog2(DEPTH + 1);

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [W-1:0]  sample_in = '0;
    logic          sample_in_valid = 1'b0;
    logic          sample_in_ready;
    logic          enable = 1'b0;
    logic          aud_pwm;
    logic          underflow;
    logic [CW-1:0] fifo_count;

    int pass_cnt  = 0;
    int total_cnt = 0;

    audio_pwm_tx #(
        .CPU_CLOCK_FREQ (100_000_000),
        .SAMPLE_WIDTH   (W),
        .FIFO_DEPTH     (DEPTH)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .sample_in       (sample_in),
        .sample_in_valid (sample_in_valid),
        .sample_in_ready (sample_in_ready),
        .enable          (enable),
        .aud_pwm         (aud_pwm),
        .underflow       (underflow),
        .fifo_count      (fifo_count)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation still running at %0t, expected completion", $time);
        $fatal(1, "timeout");
    end

    task automatic apply_reset();
        enable          = 1'b0;
        sample_in_valid = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
    endtask

    // Called at a negedge; the push lands on the following posedge.
    task automatic push(input logic [W-1:0] v);
        sample_in       = v;
        sample_in_valid = 1'b1;
        @(negedge clk);
        sample_in_valid = 1'b0;
    endtask

    // Samples n negedges; indices are 1-based relative to the call.
    task automatic run_window(input int n, output int highs, output int first_high,
                              output int ufs, output int first_uf);
        highs = 0; first_high = 0; ufs = 0; first_uf = 0;
        for (int j = 1; j <= n; j++) begin
            @(negedge clk);
            if (aud_pwm === 1'b1) begin
                highs++;
                if (first_high == 0) first_high = j;
            end
            if (underflow === 1'b1) begin
                ufs++;
                if (first_uf == 0) first_uf = j;
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        @(negedge clk);
        total_cnt++; if (aud_pwm !== 1'b0) $display("FAIL reset_aud_pwm: got %b expected 0", aud_pwm); else pass_cnt++;
        total_cnt++; if (underflow !== 1'b0) $display("FAIL reset_underflow: got %b expected 0", underflow); else pass_cnt++;
        total_cnt++; if (fifo_count !== CW'(0)) $display("FAIL reset_fifo_count: got %0d expected 0", fifo_count); else pass_cnt++;
        total_cnt++; if (sample_in_ready !== 1'b1) $display("FAIL reset_ready: got %b expected 1", sample_in_ready); else pass_cnt++;
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_fill_full();
        logic [W-1:0] vals [5];
        vals = '{10'd100, 10'd200, 10'd300, 10'd400, 10'd999};
        apply_reset();
        for (int i = 0; i < 5; i++) begin
            sample_in       = vals[i];
            sample_in_valid = 1'b1;
            total_cnt++;
            if (sample_in_ready !== (i < DEPTH))
                $display("FAIL fill_ready_%0d: got %b expected %b", i, sample_in_ready, (i < DEPTH));
            else pass_cnt++;
            @(negedge clk);
        end
        sample_in_valid = 1'b0;
        total_cnt++; if (fifo_count !== CW'(4)) $display("FAIL fill_count: got %0d expected 4", fifo_count); else pass_cnt++;
        total_cnt++; if (sample_in_ready !== 1'b0) $display("FAIL fill_ready_full: got %b expected 0", sample_in_ready); else pass_cnt++;
        total_cnt++; if (aud_pwm !== 1'b0) $display("FAIL fill_aud_pwm: got %b expected 0", aud_pwm); else pass_cnt++;
    endtask

    task automatic test_duty();
        int h, fh, u, fu;
        apply_reset();
        push(10'd256);
        enable = 1'b1;
        run_window(PERIOD, h, fh, u, fu);
        total_cnt++; if (h != 0) $display("FAIL duty_p1_highs: got %0d expected 0", h); else pass_cnt++;
        total_cnt++; if (u != 0) $display("FAIL duty_p1_underflow: got %0d expected 0", u); else pass_cnt++;
        run_window(PERIOD, h, fh, u, fu);
        total_cnt++; if (h != 256) $display("FAIL duty_p2_highs: got %0d expected 256", h); else pass_cnt++;
        // Load at window cycle 1023 of period 1, first high two cycles later = relative 1.
        total_cnt++; if (fh != 1) $display("FAIL duty_first_high: got %0d expected 1", fh); else pass_cnt++;
        total_cnt++; if (fu != PERIOD - 1) $display("FAIL duty_p2_uf_pos: got %0d expected %0d", fu, PERIOD - 1); else pass_cnt++;
    endtask

    task automatic test_extreme();
        int h, fh, u, fu;
        apply_reset();
        push(10'd1023);
        push(10'd0);
        enable = 1'b1;
        run_window(PERIOD, h, fh, u, fu);
        run_window(PERIOD, h, fh, u, fu);
        total_cnt++; if (h != 1023) $display("FAIL extreme_1023_highs: got %0d expected 1023", h); else pass_cnt++;
        run_window(PERIOD, h, fh, u, fu);
        total_cnt++; if (h != 0) $display("FAIL extreme_0_highs: got %0d expected 0", h); else pass_cnt++;
    endtask

    task automatic test_underflow_hold();
        int h, fh, u, fu;
        apply_reset();
        push(10'd512);
        enable = 1'b1;
        run_window(PERIOD, h, fh, u, fu);
        total_cnt++; if (u != 0) $display("FAIL uf_p1_count: got %0d expected 0", u); else pass_cnt++;
        run_window(PERIOD, h, fh, u, fu);
        total_cnt++; if (h != 512) $display("FAIL uf_p2_highs: got %0d expected 512", h); else pass_cnt++;
        total_cnt++; if (u != 1) $display("FAIL uf_p2_count: got %0d expected 1", u); else pass_cnt++;
        total_cnt++; if (fu != PERIOD - 1) $display("FAIL uf_p2_pos: got %0d expected %0d", fu, PERIOD - 1); else pass_cnt++;
        run_window(PERIOD, h, fh, u, fu);
        total_cnt++; if (h != 512) $display("FAIL uf_p3_held_highs: got %0d expected 512", h); else pass_cnt++;
    endtask

    task automatic test_push_on_load();
        int h, fh, u, fu;
        apply_reset();
        push(10'd100);
        push(10'd200);
        push(10'd300);
        enable = 1'b1;
        run_window(PERIOD, h, fh, u, fu);
        h = 0;
        for (int j = 1; j <= PERIOD; j++) begin
            @(negedge clk);
            if (aud_pwm === 1'b1) h++;
            if (j == PERIOD - 1) begin
                total_cnt++; if (fifo_count !== CW'(2)) $display("FAIL pol_count_before: got %0d expected 2", fifo_count); else pass_cnt++;
                total_cnt++; if (underflow !== 1'b0) $display("FAIL pol_underflow: got %b expected 0", underflow); else pass_cnt++;
                sample_in       = 10'd400;
                sample_in_valid = 1'b1;
            end
            if (j == PERIOD) begin
                sample_in_valid = 1'b0;
                total_cnt++; if (fifo_count !== CW'(2)) $display("FAIL pol_count_after: got %0d expected 2", fifo_count); else pass_cnt++;
            end
        end
        total_cnt++; if (h != 100) $display("FAIL pol_p2_highs: got %0d expected 100", h); else pass_cnt++;
        run_window(PERIOD, h, fh, u, fu);
        total_cnt++; if (h != 200) $display("FAIL pol_p3_highs: got %0d expected 200", h); else pass_cnt++;
        run_window(PERIOD, h, fh, u, fu);
        total_cnt++; if (h != 300) $display("FAIL pol_p4_highs: got %0d expected 300", h); else pass_cnt++;
        run_window(PERIOD, h, fh, u, fu);
        total_cnt++; if (h != 400) $display("FAIL pol_p5_highs: got %0d expected 400", h); else pass_cnt++;
    endtask

    task automatic test_async_reset();
        int h, fh, u, fu;
        apply_reset();
        for (int i = 0; i < 4; i++) push(10'd500);
        enable = 1'b1;
        run_window(PERIOD, h, fh, u, fu);
        run_window(300, h, fh, u, fu);
        // Counter now 300 in period 2 with duty 500: output high, 3 queued.
        total_cnt++; if (aud_pwm !== 1'b1) $display("FAIL ar_aud_before: got %b expected 1", aud_pwm); else pass_cnt++;
        total_cnt++; if (fifo_count !== CW'(3)) $display("FAIL ar_count_before: got %0d expected 3", fifo_count); else pass_cnt++;
        #1 rst = 1'b1;
        #1;
        total_cnt++; if (aud_pwm !== 1'b0) $display("FAIL ar_aud_during: got %b expected 0", aud_pwm); else pass_cnt++;
        total_cnt++; if (fifo_count !== CW'(0)) $display("FAIL ar_count_during: got %0d expected 0", fifo_count); else pass_cnt++;
        total_cnt++; if (sample_in_ready !== 1'b1) $display("FAIL ar_ready_during: got %b expected 1", sample_in_ready); else pass_cnt++;
        @(negedge clk);
        rst = 1'b0;
        run_window(PERIOD, h, fh, u, fu);
        total_cnt++; if (h != 0) $display("FAIL ar_highs_after: got %0d expected 0", h); else pass_cnt++;
        total_cnt++; if (fu != PERIOD - 1) $display("FAIL ar_restart_uf_pos: got %0d expected %0d", fu, PERIOD - 1); else pass_cnt++;
    endtask

    initial begin
        test_reset();
        test_fill_full();
        test_duty();
        test_extreme();
        test_underflow_hold();
        test_push_on_load();
        test_async_reset();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule : tb_audio_pwm_tx
`default_nettype wire
